// File: rtl/alu_rs_pkg.sv
// Shared constants and ALU op encodings for the ALU reservation station.
package alu_rs_pkg;

  localparam int RS_SIZE_DEFAULT        = 8;
  localparam int ROB_SIZE_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'b000,
    ALU_SLL     = 3'b001,
    ALU_SLT     = 3'b010,
    ALU_SLTU    = 3'b011,
    ALU_XOR     = 3'b100,
    ALU_SRL_SRA = 3'b101,
    ALU_OR      = 3'b110,
    ALU_AND     = 3'b111
  } alu_op_e;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit finder: returns the index of the lowest asserted request and a found flag.
module rs_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive on a CDB,
// then issues the lowest-index ready entry to the ALU, one per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE        = RS_SIZE_DEFAULT,
  parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      disp_valid_in,
  input  logic [2:0]                disp_op_L1_in,
  input  logic                      disp_op_L2_in,
  input  logic                      disp_is_I_type_in,
  input  logic [31:0]               disp_vj_in,
  input  logic [31:0]               disp_vk_in,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qj_in,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qk_in,
  input  logic                      disp_qj_wait_in,
  input  logic                      disp_qk_wait_in,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_rob_id_in,
  output logic                      full_out,
  input  logic                      cdb0_ready_in,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb0_rob_id_in,
  input  logic [31:0]               cdb0_value_in,
  input  logic                      cdb1_ready_in,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb1_rob_id_in,
  input  logic [31:0]               cdb1_value_in,
  output logic                      valid_out,
  output logic [31:0]               opr1_out,
  output logic [31:0]               opr2_out,
  output logic [ROB_SIZE_WIDTH-1:0] rob_id_out,
  output logic [2:0]                alu_op_L1_out,
  output logic                      alu_op_L2_out,
  output logic                      alu_is_I_type_out
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int RW = ROB_SIZE_WIDTH;

  // Control state (reset) and payload state (no reset needed while not busy).
  logic [RS_SIZE-1:0] busy_q, busy_d, wj_q, wj_d, wk_q, wk_d;
  logic [RS_SIZE-1:0] op_b_q, op_b_d, is_i_q, is_i_d;
  alu_op_e            op_a_q [RS_SIZE];
  alu_op_e            op_a_d [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vj_d   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];
  logic [31:0]        vk_d   [RS_SIZE];
  logic [RW-1:0]      qj_q   [RS_SIZE];
  logic [RW-1:0]      qj_d   [RS_SIZE];
  logic [RW-1:0]      qk_q   [RS_SIZE];
  logic [RW-1:0]      qk_d   [RS_SIZE];
  logic [RW-1:0]      rob_q  [RS_SIZE];
  logic [RW-1:0]      rob_d  [RS_SIZE];

  logic               valid_q, valid_d;
  logic [31:0]        opr1_q, opr1_d, opr2_q, opr2_d;
  logic [RW-1:0]      rob_out_q, rob_out_d;
  alu_op_e            op_l1_q, op_l1_d;
  logic               op_l2_q, op_l2_d, is_i_out_q, is_i_out_d;

  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic [IW-1:0]      free_idx, iss_idx;
  logic               free_found, iss_found;

  assign free_vec  = ~busy_q;
  assign ready_vec = busy_q & ~wj_q & ~wk_q;
  assign full_out  = &busy_q;

  rs_prio_enc #(.N(RS_SIZE), .W(IW)) u_free_enc (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(IW)) u_ready_enc (
    .req_i   (ready_vec),
    .idx_o   (iss_idx),
    .found_o (iss_found)
  );

  // cdb0 has priority when both ports carry the same tag.
  function automatic logic cdb_hit(input logic [RW-1:0] tag);
    return (cdb0_ready_in && (cdb0_rob_id_in == tag)) ||
           (cdb1_ready_in && (cdb1_rob_id_in == tag));
  endfunction

  function automatic logic [31:0] cdb_val(input logic [RW-1:0] tag);
    return (cdb0_ready_in && (cdb0_rob_id_in == tag)) ? cdb0_value_in : cdb1_value_in;
  endfunction

  always_comb begin
    busy_d     = busy_q;
    wj_d       = wj_q;
    wk_d       = wk_q;
    op_b_d     = op_b_q;
    is_i_d     = is_i_q;
    op_a_d     = op_a_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    rob_d      = rob_q;
    valid_d    = 1'b0;
    opr1_d     = opr1_q;
    opr2_d     = opr2_q;
    rob_out_d  = rob_out_q;
    op_l1_d    = op_l1_q;
    op_l2_d    = op_l2_q;
    is_i_out_d = is_i_out_q;

    if (rdy_in) begin
      if (need_flush_in) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && wj_q[i] && cdb_hit(qj_q[i])) begin
            vj_d[i] = cdb_val(qj_q[i]);
            wj_d[i] = 1'b0;
          end
          if (busy_q[i] && wk_q[i] && cdb_hit(qk_q[i])) begin
            vk_d[i] = cdb_val(qk_q[i]);
            wk_d[i] = 1'b0;
          end
        end

        if (iss_found) begin
          valid_d         = 1'b1;
          opr1_d          = vj_q[iss_idx];
          opr2_d          = vk_q[iss_idx];
          rob_out_d       = rob_q[iss_idx];
          op_l1_d         = op_a_q[iss_idx];
          op_l2_d         = op_b_q[iss_idx];
          is_i_out_d      = is_i_q[iss_idx];
          busy_d[iss_idx] = 1'b0;
        end

        // Free slot comes from registered busy bits, so an issue never makes room this edge.
        if (disp_valid_in && free_found) begin
          busy_d[free_idx] = 1'b1;
          op_a_d[free_idx] = alu_op_e'(disp_op_L1_in);
          op_b_d[free_idx] = disp_op_L2_in;
          is_i_d[free_idx] = disp_is_I_type_in;
          rob_d[free_idx]  = disp_rob_id_in;
          qj_d[free_idx]   = disp_qj_in;
          qk_d[free_idx]   = disp_qk_in;
          vj_d[free_idx]   = disp_vj_in;
          vk_d[free_idx]   = disp_vk_in;
          wj_d[free_idx]   = disp_qj_wait_in;
          wk_d[free_idx]   = disp_qk_wait_in;
          if (disp_qj_wait_in && cdb_hit(disp_qj_in)) begin
            vj_d[free_idx] = cdb_val(disp_qj_in);
            wj_d[free_idx] = 1'b0;
          end
          if (disp_qk_wait_in && cdb_hit(disp_qk_in)) begin
            vk_d[free_idx] = cdb_val(disp_qk_in);
            wk_d[free_idx] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q     <= '0;
      wj_q       <= '0;
      wk_q       <= '0;
      valid_q    <= 1'b0;
      opr1_q     <= '0;
      opr2_q     <= '0;
      rob_out_q  <= '0;
      op_l1_q    <= ALU_ADD_SUB;
      op_l2_q    <= 1'b0;
      is_i_out_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      wj_q       <= wj_d;
      wk_q       <= wk_d;
      valid_q    <= valid_d;
      opr1_q     <= opr1_d;
      opr2_q     <= opr2_d;
      rob_out_q  <= rob_out_d;
      op_l1_q    <= op_l1_d;
      op_l2_q    <= op_l2_d;
      is_i_out_q <= is_i_out_d;
    end
  end

  always_ff @(posedge clk_in) begin
    op_b_q <= op_b_d;
    is_i_q <= is_i_d;
    op_a_q <= op_a_d;
    vj_q   <= vj_d;
    vk_q   <= vk_d;
    qj_q   <= qj_d;
    qk_q   <= qk_d;
    rob_q  <= rob_d;
  end

  assign valid_out         = valid_q;
  assign opr1_out          = opr1_q;
  assign opr2_out          = opr2_q;
  assign rob_id_out        = rob_out_q;
  assign alu_op_L1_out     = op_l1_q;
  assign alu_op_L2_out     = op_l2_q;
  assign alu_is_I_type_out = is_i_out_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic against a
// slot-list reference model of the reservation station.
module tb_alu_rs;

  localparam int RS = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, need_flush_in, disp_valid_in;
  logic [2:0]  disp_op_L1_in;
  logic        disp_op_L2_in, disp_is_I_type_in;
  logic [31:0] disp_vj_in, disp_vk_in;
  logic [3:0]  disp_qj_in, disp_qk_in, disp_rob_id_in;
  logic        disp_qj_wait_in, disp_qk_wait_in;
  logic        full_out;
  logic        cdb0_ready_in, cdb1_ready_in;
  logic [3:0]  cdb0_rob_id_in, cdb1_rob_id_in;
  logic [31:0] cdb0_value_in, cdb1_value_in;
  logic        valid_out;
  logic [31:0] opr1_out, opr2_out;
  logic [3:0]  rob_id_out;
  logic [2:0]  alu_op_L1_out;
  logic        alu_op_L2_out, alu_is_I_type_out;

  logic [73:0] dut_bus;
  assign dut_bus = {valid_out, rob_id_out, opr1_out, opr2_out,
                    alu_op_L1_out, alu_op_L2_out, alu_is_I_type_out};

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  alu_rs #(.RS_SIZE(RS), .ROB_SIZE_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .disp_valid_in(disp_valid_in), .disp_op_L1_in(disp_op_L1_in), .disp_op_L2_in(disp_op_L2_in),
    .disp_is_I_type_in(disp_is_I_type_in), .disp_vj_in(disp_vj_in), .disp_vk_in(disp_vk_in),
    .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in), .disp_qj_wait_in(disp_qj_wait_in),
    .disp_qk_wait_in(disp_qk_wait_in), .disp_rob_id_in(disp_rob_id_in), .full_out(full_out),
    .cdb0_ready_in(cdb0_ready_in), .cdb0_rob_id_in(cdb0_rob_id_in), .cdb0_value_in(cdb0_value_in),
    .cdb1_ready_in(cdb1_ready_in), .cdb1_rob_id_in(cdb1_rob_id_in), .cdb1_value_in(cdb1_value_in),
    .valid_out(valid_out), .opr1_out(opr1_out), .opr2_out(opr2_out), .rob_id_out(rob_id_out),
    .alu_op_L1_out(alu_op_L1_out), .alu_op_L2_out(alu_op_L2_out),
    .alu_is_I_type_out(alu_is_I_type_out)
  );

  // Reference model: a list of slots, each either empty or holding a waiting instruction.
  typedef struct {
    bit          busy;
    logic [2:0]  opa;
    logic        opb, isi;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk, rob;
    bit          wj, wk;
  } ent_t;

  ent_t        m_rs[RS];
  logic [73:0] m_out;

  function automatic bit m_full();
    foreach (m_rs[i]) if (!m_rs[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit bcast(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    if (cdb0_ready_in && cdb0_rob_id_in == tag) begin val = cdb0_value_in; return 1'b1; end
    if (cdb1_ready_in && cdb1_rob_id_in == tag) begin val = cdb1_value_in; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_reset();
    foreach (m_rs[i]) m_rs[i].busy = 1'b0;
    m_out = '0;
  endtask

  // Apply the effect of the coming clock edge given the inputs currently driven.
  task automatic model_edge();
    int sel = -1;
    int slot = -1;
    bit was_full;
    logic [31:0] v;
    if (!rst_n_in) return;
    m_out[73] = 1'b0;
    if (!rdy_in) return;
    if (need_flush_in) begin
      foreach (m_rs[i]) m_rs[i].busy = 1'b0;
      return;
    end
    was_full = m_full();
    foreach (m_rs[i]) begin
      if (m_rs[i].busy && !m_rs[i].wj && !m_rs[i].wk && sel < 0) sel = i;
      if (!m_rs[i].busy && slot < 0) slot = i;
    end
    foreach (m_rs[i]) begin
      if (m_rs[i].busy && m_rs[i].wj && bcast(m_rs[i].qj, v)) begin m_rs[i].vj = v; m_rs[i].wj = 0; end
      if (m_rs[i].busy && m_rs[i].wk && bcast(m_rs[i].qk, v)) begin m_rs[i].vk = v; m_rs[i].wk = 0; end
    end
    if (sel >= 0) begin
      m_out = {1'b1, m_rs[sel].rob, m_rs[sel].vj, m_rs[sel].vk,
               m_rs[sel].opa, m_rs[sel].opb, m_rs[sel].isi};
      m_rs[sel].busy = 1'b0;
    end
    if (disp_valid_in && !was_full) begin
      m_rs[slot] = '{busy: 1'b1, opa: disp_op_L1_in, opb: disp_op_L2_in, isi: disp_is_I_type_in,
                     vj: disp_vj_in, vk: disp_vk_in, qj: disp_qj_in, qk: disp_qk_in,
                     rob: disp_rob_id_in, wj: disp_qj_wait_in, wk: disp_qk_wait_in};
      if (disp_qj_wait_in && bcast(disp_qj_in, v)) begin m_rs[slot].vj = v; m_rs[slot].wj = 0; end
      if (disp_qk_wait_in && bcast(disp_qk_in, v)) begin m_rs[slot].vk = v; m_rs[slot].wk = 0; end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; need_flush_in = 1'b0; disp_valid_in = 1'b0;
    disp_op_L1_in = '0; disp_op_L2_in = 1'b0; disp_is_I_type_in = 1'b0;
    disp_vj_in = '0; disp_vk_in = '0; disp_qj_in = '0; disp_qk_in = '0;
    disp_qj_wait_in = 1'b0; disp_qk_wait_in = 1'b0; disp_rob_id_in = '0;
    cdb0_ready_in = 1'b0; cdb0_rob_id_in = '0; cdb0_value_in = '0;
    cdb1_ready_in = 1'b0; cdb1_rob_id_in = '0; cdb1_value_in = '0;
  endtask

  task automatic disp(input logic [2:0] opa, input logic opb, input logic [31:0] vj,
                      input logic [31:0] vk, input logic [3:0] qj, input bit wj,
                      input logic [3:0] qk, input bit wk, input logic [3:0] rob);
    disp_valid_in = 1'b1; disp_op_L1_in = opa; disp_op_L2_in = opb; disp_is_I_type_in = 1'b0;
    disp_vj_in = vj; disp_vk_in = vk; disp_qj_in = qj; disp_qk_in = qk;
    disp_qj_wait_in = wj; disp_qk_wait_in = wk; disp_rob_id_in = rob;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if (dut_bus !== 74'd0 || full_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got bus=%h full=%b exp bus=0 full=0", dut_bus, full_out);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    disp(3'b000, 1'b0, 32'd5, 32'd7, 4'd0, 0, 4'd0, 0, 4'd3);
    tick();
    idle_inputs();
    n_vec++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_issue got %b exp 0", valid_out); end
    tick();
    n_vec++;
    if (dut_bus !== m_out || {valid_out, opr1_out, opr2_out, rob_id_out} !== {1'b1, 32'd5, 32'd7, 4'd3}) begin
      n_fail++; $display("FAIL basic_issue got %h exp %h", dut_bus, m_out);
    end
    tick();
    n_vec++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got %b exp 0", valid_out); end
  endtask

  task automatic test_wakeup();
    do_reset();
    disp(3'b000, 1'b1, 32'd0, 32'd40, 4'd2, 1, 4'd0, 0, 4'd7);
    tick();
    idle_inputs();
    for (int e = 1; e <= 4; e++) begin
      if (e == 4) begin cdb1_ready_in = 1'b1; cdb1_rob_id_in = 4'd2; cdb1_value_in = 32'd100; end
      tick();
      n_vec++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL wakeup_wait edge%0d got %b exp 0", e, valid_out); end
    end
    idle_inputs();
    tick();
    n_vec++;
    if (dut_bus !== m_out || opr1_out !== 32'd100 || valid_out !== 1'b1 || alu_op_L2_out !== 1'b1) begin
      n_fail++; $display("FAIL wakeup_issue got %h exp %h", dut_bus, m_out);
    end
  endtask

  task automatic test_same_edge_capture();
    do_reset();
    disp(3'b111, 1'b0, 32'hF0, 32'd0, 4'd0, 0, 4'd6, 1, 4'd11);
    cdb0_ready_in = 1'b1; cdb0_rob_id_in = 4'd6; cdb0_value_in = 32'd9;
    cdb1_ready_in = 1'b1; cdb1_rob_id_in = 4'd6; cdb1_value_in = 32'd77;
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (dut_bus !== m_out || opr2_out !== 32'd9 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_capture got %h exp %h", dut_bus, m_out);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < RS; i++) begin
      disp(3'b100, 1'b0, 32'd0, 32'(i + 200), 4'(i + 8), 1, 4'd0, 0, 4'(i));
      tick();
    end
    idle_inputs();
    n_vec++;
    if (full_out !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", full_out); end
    disp(3'b000, 1'b0, 32'd1, 32'd1, 4'd0, 0, 4'd0, 0, 4'd15);
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (valid_out !== 1'b0 || full_out !== m_full()) begin
      n_fail++; $display("FAIL full_drop got valid=%b full=%b exp valid=0 full=1", valid_out, full_out);
    end
    cdb0_ready_in = 1'b1; cdb0_rob_id_in = 4'd13; cdb0_value_in = 32'd55;
    cdb1_ready_in = 1'b1; cdb1_rob_id_in = 4'd10; cdb1_value_in = 32'd22;
    tick();
    idle_inputs();
    // Dispatch lands on the edge that issues entry 2; the station is still full, so it drops.
    disp(3'b000, 1'b0, 32'd3, 32'd3, 4'd0, 0, 4'd0, 0, 4'd14);
    tick();
    idle_inputs();
    n_vec++;
    if (dut_bus !== m_out || rob_id_out !== 4'd2 || opr1_out !== 32'd22) begin
      n_fail++; $display("FAIL full_first_issue got %h exp %h", dut_bus, m_out);
    end
    tick();
    n_vec++;
    if (dut_bus !== m_out || rob_id_out !== 4'd5 || opr1_out !== 32'd55) begin
      n_fail++; $display("FAIL full_second_issue got %h exp %h", dut_bus, m_out);
    end
    tick();
    n_vec++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL full_no_third got %b exp 0", valid_out); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp(3'b001, 1'b0, 32'd0, 32'd0, 4'(i + 1), 1, 4'd0, 0, 4'(i));
      tick();
    end
    idle_inputs();
    need_flush_in = 1'b1;
    disp(3'b000, 1'b0, 32'd1, 32'd2, 4'd0, 0, 4'd0, 0, 4'd9);
    cdb0_ready_in = 1'b1; cdb0_rob_id_in = 4'd1;
    tick();
    idle_inputs();
    n_vec++;
    if (full_out !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear got full=%b valid=%b exp 0 0", full_out, valid_out);
    end
    cdb0_ready_in = 1'b1; cdb0_rob_id_in = 4'd2;
    cdb1_ready_in = 1'b1; cdb1_rob_id_in = 4'd3;
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue got %b exp 0", valid_out); end
    disp(3'b110, 1'b0, 32'd31, 32'd32, 4'd0, 0, 4'd0, 0, 4'd12);
    tick();
    disp(3'b010, 1'b0, 32'd41, 32'd42, 4'd0, 0, 4'd0, 0, 4'd13);
    tick();
    idle_inputs();
    n_vec++;
    if (dut_bus !== m_out || rob_id_out !== 4'd12) begin
      n_fail++; $display("FAIL flush_fresh got %h exp %h", dut_bus, m_out);
    end
    tick();
    n_vec++;
    if (dut_bus !== m_out || rob_id_out !== 4'd13) begin
      n_fail++; $display("FAIL flush_fresh_slot1 got %h exp %h", dut_bus, m_out);
    end
  endtask

  task automatic test_stall();
    do_reset();
    disp(3'b011, 1'b1, 32'd8, 32'd9, 4'd0, 0, 4'd0, 0, 4'd9);
    tick();
    for (int c = 0; c < 3; c++) begin
      rdy_in = 1'b0;
      disp(3'b000, 1'b0, 32'd1, 32'd1, 4'd0, 0, 4'd0, 0, 4'd1);
      tick();
      n_vec++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_hold cyc%0d got %b exp 0", c, valid_out); end
    end
    idle_inputs();
    tick();
    n_vec++;
    if (dut_bus !== m_out || rob_id_out !== 4'd9 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL stall_resume got %h exp %h", dut_bus, m_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp(3'b101, 1'b0, 32'd0, 32'd0, 4'(i + 4), 1, 4'd0, 0, 4'(i));
      tick();
    end
    disp(3'b101, 1'b1, 32'hDEAD, 32'hBEEF, 4'd0, 0, 4'd0, 0, 4'd8);
    tick();
    idle_inputs();
    tick();
    #1;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (dut_bus !== 74'd0 || full_out !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got bus=%h full=%b exp 0 0", dut_bus, full_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    cdb0_ready_in = 1'b1; cdb0_rob_id_in = 4'd4;
    cdb1_ready_in = 1'b1; cdb1_rob_id_in = 4'd5;
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL async_discard got %b exp 0", valid_out); end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 600; it++) begin
      idle_inputs();
      rdy_in        = ($urandom_range(0, 7) != 0);
      need_flush_in = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        disp(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      disp_is_I_type_in = 1'($urandom_range(0, 1));
      cdb0_ready_in = 1'($urandom_range(0, 1));
      cdb0_rob_id_in = 4'($urandom_range(0, 15));
      cdb0_value_in = $urandom;
      cdb1_ready_in = 1'($urandom_range(0, 1));
      cdb1_rob_id_in = 4'($urandom_range(0, 15));
      cdb1_value_in = $urandom;
      n_vec++;
      if (full_out !== m_full()) begin
        n_fail++; $display("FAIL rand_full it%0d got %b exp %b", it, full_out, m_full());
      end
      tick();
      n_vec++;
      if (dut_bus !== m_out) begin
        n_fail++; $display("FAIL rand_out it%0d got %h exp %h", it, dut_bus, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_same_edge_capture();
    test_full();
    test_flush();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
